// File: rtl/vc_pinbus_pkg.sv
// Shared definitions for the vc CPU pin-level memory protocol.
// Holds the responder state encoding, address byte count helpers, the
// byte-lane select rule and the pin positions used by the CPU's driver.
package vc_pinbus_pkg;

    localparam int PA_DEFAULT = 24;
    localparam int RV_BITS    = 16;

    // Bit positions within the CPU's dedicated pins.
    localparam int UO_REQ_BIT  = 0;
    localparam int UO_WR_BIT   = 1;
    localparam int UO_BYTE_BIT = 2;
    localparam int UI_RDY_BIT  = 0;

    // Number of address bytes sent MSB first for a given address width.
    function automatic int addr_bytes(input int pa);
        return pa / 8;
    endfunction

    localparam int ADDR_BYTES = addr_bytes(PA_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WDAT = 3'd2,
        ST_MEM  = 3'd3,
        ST_RDAT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Big-endian lanes: even byte address is the high lane.
    function automatic logic [1:0] lane_be(input logic addr0);
        return addr0 ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/vc_pin_shift.sv
// Byte-serial shift-in register: each shifted byte enters at the LSB end.
// Ports: i_clr zeroes data and count, i_shift appends i_byte (a shift in
// the same cycle as a clear starts from zero), o_cnt counts bytes taken.
module vc_pin_shift #(
    parameter int W  = 24,
    parameter int CW = $clog2(W / 8 + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_shift,
    input  logic [7:0]    i_byte,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_cnt
);

    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_base;
    logic [CW-1:0] w_cnt_base;

    assign w_base     = i_clr ? '0 : r_data;
    assign w_cnt_base = i_clr ? '0 : r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= (w_base << 8) | W'(i_byte);
            r_cnt  <= w_cnt_base + CW'(1);
        end else if (i_clr) begin
            r_data <= '0;
            r_cnt  <= '0;
        end
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/vc_pin_mem_responder.sv
// Memory-side responder for the vc CPU pin bus: decodes byte-serial
// address/write data, issues one word access to a backing memory, and
// returns read data byte-serially with rdy. Ports: CPU pins (bus_in,
// bus_out, bus_oe, req, wr, byte_op, rdy) and the memory port (mem_*).
module vc_pin_mem_responder
    import vc_pinbus_pkg::*;
#(
    parameter int PA = PA_DEFAULT,
    parameter int RV = RV_BITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    bus_in,
    output logic [7:0]    bus_out,
    output logic          bus_oe,
    input  logic          req,
    input  logic          wr,
    input  logic          byte_op,
    output logic          rdy,
    output logic [PA-2:0] mem_addr,
    output logic [RV-1:0] mem_wdata,
    output logic [1:0]    mem_be,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [RV-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int NB = addr_bytes(PA);
    localparam int CW = $clog2(NB + 1);

    state_t        r_state;
    state_t        w_next;

    logic          r_wr;
    logic          r_byte_op;
    logic          r_we;
    logic          r_re;
    logic          r_issued;   // request already launched in this MEM visit
    logic          r_abort;    // req dropped while in MEM
    logic          r_wack;     // one-cycle write completion strobe
    logic          r_rsel;     // second (low) byte of a 16-bit read
    logic [1:0]    r_be;
    logic [RV-1:0] r_wdata;
    logic [RV-1:0] r_rdata;

    logic [PA-1:0] w_addr;
    logic [CW-1:0] w_acnt;
    logic [15:0]   w_dat;
    logic [1:0]    w_dcnt;
    logic          w_ack;
    logic          w_addr_last;
    logic          w_wdat_last;
    logic          w_a_clr;
    logic          w_a_shift;
    logic          w_d_shift;

    vc_pin_shift #(.W(PA), .CW(CW)) u_addr_shift (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_a_clr),
        .i_shift (w_a_shift),
        .i_byte  (bus_in),
        .o_data  (w_addr),
        .o_cnt   (w_acnt)
    );

    vc_pin_shift #(.W(16), .CW(2)) u_data_shift (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_a_clr),
        .i_shift (w_d_shift),
        .i_byte  (bus_in),
        .o_data  (w_dat),
        .o_cnt   (w_dcnt)
    );

    // Only an acknowledge for a request we actually raised counts.
    assign w_ack       = (r_we | r_re) & mem_ack;
    assign w_addr_last = (w_acnt == CW'(NB - 1));
    assign w_wdat_last = r_byte_op | (w_dcnt == 2'd1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (NB == 1) begin
                        w_next = wr ? ST_WDAT : ST_MEM;
                    end else begin
                        w_next = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (!req) begin
                    w_next = ST_IDLE;
                end else if (w_addr_last) begin
                    w_next = r_wr ? ST_WDAT : ST_MEM;
                end
            end
            ST_WDAT: begin
                if (!req) begin
                    w_next = ST_IDLE;
                end else if (w_wdat_last) begin
                    w_next = ST_MEM;
                end
            end
            ST_MEM: begin
                // An access in flight always runs to its acknowledge.
                if (w_ack) begin
                    if (r_abort || !req) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = r_wr ? ST_DONE : ST_RDAT;
                    end
                end
            end
            ST_RDAT: begin
                if (!req) begin
                    w_next = ST_IDLE;
                end else if (r_byte_op || r_rsel) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!req) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_a_clr   = (r_state == ST_IDLE) && req;
        w_a_shift = w_a_clr || ((r_state == ST_ADDR) && req);
        w_d_shift = (r_state == ST_WDAT) && req;
        bus_oe    = (r_state == ST_RDAT);
        rdy       = bus_oe | r_wack;
        bus_out   = 8'h00;
        if (r_state == ST_RDAT) begin
            if (r_byte_op) begin
                bus_out = r_be[1] ? r_rdata[15:8] : r_rdata[7:0];
            end else begin
                bus_out = r_rsel ? r_rdata[7:0] : r_rdata[15:8];
            end
        end
    end

    // Transaction attributes, memory request and captured data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr      <= 1'b0;
            r_byte_op <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_issued  <= 1'b0;
            r_abort   <= 1'b0;
            r_wack    <= 1'b0;
            r_rsel    <= 1'b0;
            r_be      <= 2'b00;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && req) begin
                r_wr      <= wr;
                r_byte_op <= byte_op;
            end

            r_wack <= 1'b0;
            if (r_state == ST_MEM) begin
                if (!req) begin
                    r_abort <= 1'b1;
                end
                if (!r_issued) begin
                    r_issued <= 1'b1;
                    r_we     <= r_wr;
                    r_re     <= !r_wr;
                    r_be     <= r_byte_op ? lane_be(w_addr[0]) : 2'b11;
                    if (r_wr) begin
                        r_wdata <= r_byte_op ? {w_dat[7:0], w_dat[7:0]} : w_dat;
                    end
                end else if (w_ack) begin
                    r_we <= 1'b0;
                    r_re <= 1'b0;
                    if (!r_wr) begin
                        r_rdata <= mem_rdata;
                    end
                    r_wack <= r_wr && req && !r_abort;
                end
            end else begin
                r_issued <= 1'b0;
                r_abort  <= 1'b0;
            end

            r_rsel <= (r_state == ST_RDAT) && !r_rsel && req;
        end
    end

    assign mem_addr  = w_addr[PA-1:1];
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign mem_we    = r_we;
    assign mem_re    = r_re;

endmodule

// File: tb/tb_vc_pin_mem_responder.sv
// Bench for vc_pin_mem_responder: directed protocol scenarios followed by
// random transactions checked against an 8-word big-endian memory model.
module tb_vc_pin_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        req;
    logic        wr;
    logic        byte_op;
    logic        rdy;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference memory: word index = address bits [3:1].
    logic [15:0] ref_mem [0:7];

    vc_pin_mem_responder #(.PA(24), .RV(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .req       (req),
        .wr        (wr),
        .byte_op   (byte_op),
        .rdy       (rdy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input bit w, input bit b, input logic [23:0] a);
        req     = 1'b1;
        wr      = w;
        byte_op = b;
        for (int i = 0; i < 3; i++) begin
            bus_in = a[23 - 8 * i -: 8];
            tick();
        end
    endtask

    // Serve the memory port: ack after the request has been high 'lat' cycles.
    // Returns at #1 after the acknowledging edge.
    task automatic mem_phase(input string tag, input bit w, input logic [22:0] ea,
                             input logic [15:0] ewd, input logic [1:0] ebe,
                             input logic [15:0] rd, input int lat);
        int  cnt     = 0;
        int  first_c = -1;
        bit  done    = 0;
        bit  bad_bus = 0;
        bit  dropped = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus_oe || rdy) bad_bus = 1;
            if (mem_we || mem_re) begin
                if (cnt == 0) begin
                    first_c = c;
                    check({tag, " we"}, mem_we, w);
                    check({tag, " re"}, mem_re, !w);
                    check({tag, " addr"}, mem_addr, ea);
                    check({tag, " be"}, mem_be, ebe);
                    if (w) check({tag, " wdata"}, mem_wdata, ewd);
                end
                cnt++;
                if (cnt == lat) begin
                    mem_rdata = rd;
                    mem_ack   = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_ack   = 1'b0;
                    done      = 1;
                end
            end else if (cnt > 0) begin
                dropped = 1;
            end
        end
        check({tag, " ack reached"}, done, 1);
        check({tag, " issue cycle"}, first_c, 1);
        check({tag, " req held"}, dropped, 0);
        check({tag, " bus quiet in mem"}, bad_bus, 0);
    endtask

    task automatic txn(input string tag, input bit w, input bit b, input logic [23:0] a,
                       input logic [15:0] wd, input int lat, input bit hold);
        int          idx;
        logic [1:0]  ebe;
        logic [15:0] ewd;
        logic [15:0] rd;
        logic [7:0]  eb0;
        bit          quiet;
        idx = int'(a[3:1]);
        ebe = b ? (a[0] ? 2'b01 : 2'b10) : 2'b11;
        ewd = b ? {wd[7:0], wd[7:0]} : wd;
        rd  = ref_mem[idx];
        send_addr(w, b, a);
        if (w) begin
            bus_in = b ? wd[7:0] : wd[15:8];
            tick();
            if (!b) begin
                bus_in = wd[7:0];
                tick();
            end
        end
        mem_phase(tag, w, a[23:1], ewd, ebe, rd, lat);
        @(negedge clk);
        check({tag, " req off after ack"}, {mem_we, mem_re}, 2'b00);
        if (w) begin
            check({tag, " rdy after ack"}, rdy, 1);
            check({tag, " oe on write"}, bus_oe, 0);
            @(negedge clk);
            check({tag, " rdy pulse end"}, rdy, 0);
            if (ebe[1]) ref_mem[idx][15:8] = ewd[15:8];
            if (ebe[0]) ref_mem[idx][7:0]  = ewd[7:0];
        end else begin
            eb0 = (b && a[0]) ? rd[7:0] : rd[15:8];
            check({tag, " byte0"}, {bus_oe, rdy, bus_out}, {2'b11, eb0});
            if (!b) begin
                @(negedge clk);
                check({tag, " byte1"}, {bus_oe, rdy, bus_out}, {2'b11, rd[7:0]});
            end
            @(negedge clk);
            check({tag, " bus released"}, {bus_oe, rdy}, 2'b00);
        end
        if (hold) begin
            quiet = 1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                bus_in = 8'($urandom);
                @(negedge clk);
                if (mem_we || mem_re || rdy || bus_oe) quiet = 0;
            end
            check({tag, " no restart while req held"}, quiet, 1);
        end
        @(posedge clk);
        #1;
        req     = 1'b0;
        wr      = 1'b0;
        byte_op = 1'b0;
        bus_in  = 8'h00;
        tick();
    endtask

    initial begin
        bit          quiet;
        bit          seen;
        logic [23:0] ra;

        reset     = 1'b1;
        req       = 1'b0;
        wr        = 1'b0;
        byte_op   = 1'b0;
        bus_in    = 8'h00;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'($urandom);
        ref_mem[0] = 16'hBEEF;
        ref_mem[1] = 16'h1234;

        repeat (3) @(negedge clk);
        check("reset outputs",
              {bus_out, bus_oe, rdy, mem_we, mem_re, mem_addr, mem_wdata, mem_be}, 64'd0);
        reset = 1'b0;
        tick();

        // 16-bit write and read
        txn("wr16", 1, 0, 24'h123456, 16'hABCD, 3, 0);
        txn("rd16", 0, 0, 24'h000010, 16'h0000, 1, 0);

        // Byte write to odd address, byte read from even address
        txn("wr8", 1, 1, 24'h000003, 16'h005A, 2, 0);
        txn("rd8", 0, 1, 24'h000002, 16'h0000, 1, 0);

        // Abort in the address phase
        req = 1'b1; wr = 1'b1; byte_op = 1'b0;
        bus_in = 8'h77; tick();
        bus_in = 8'h88; tick();
        req = 1'b0; wr = 1'b0;
        quiet = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_we || mem_re || rdy || bus_oe) quiet = 0;
        end
        check("abort addr quiet", quiet, 1);
        tick();
        txn("after abort", 0, 0, 24'h00000A, 16'h0000, 2, 0);

        // req dropped in MEM: the access completes but nothing is returned
        send_addr(0, 0, 24'h000004);
        req = 1'b0;
        quiet = 1;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rdy || bus_oe) quiet = 0;
            if (mem_re) begin
                seen = 1;
                mem_rdata = 16'hC0DE;
                mem_ack   = 1'b1;
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
            end
        end
        check("mem abort access issued", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rdy || bus_oe || mem_re || mem_we) quiet = 0;
        end
        check("mem abort no return", quiet, 1);
        tick();

        // Write completion with req held high afterwards
        txn("wr hold", 1, 0, 24'h00000C, 16'h4321, 1, 1);
        txn("rd hold", 0, 0, 24'h00000C, 16'h0000, 1, 0);

        // Async reset while a read request is outstanding
        send_addr(0, 0, 24'h00000E);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_re) seen = 1;
        end
        check("reset test re seen", seen, 1);
        #1 reset = 1'b1;
        #1;
        check("async reset outputs",
              {bus_out, bus_oe, rdy, mem_we, mem_re, mem_addr, mem_wdata, mem_be}, 64'd0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        quiet = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdy || bus_oe || mem_re || mem_we) quiet = 0;
        end
        check("post reset idle", quiet, 1);
        tick();
        txn("after reset", 0, 0, 24'h000010, 16'h0000, 1, 0);

        // Random traffic against the memory model
        for (int n = 0; n < 30; n++) begin
            ra = {16'h00A5, 8'($urandom_range(0, 15))};
            txn($sformatf("rand%0d", n), 1'($urandom), 1'($urandom), ra,
                16'($urandom), int'($urandom_range(1, 4)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
